// File: rtl/axi_ram_slave_pkg.sv
// Shared definitions for the single-beat AXI4 RAM slave: bus widths,
// response codes and the controller state encoding.
package axi_ram_slave_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_LEN_W  = 8;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;
    localparam int AXI_RESP_W = 2;

    typedef enum logic [AXI_RESP_W-1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RD_ISSUE   = 3'd1,
        ST_RD_CAPT    = 3'd2,
        ST_RD_RESP    = 3'd3,
        ST_WR_COLLECT = 3'd4,
        ST_WR_ISSUE   = 3'd5,
        ST_WR_RESP    = 3'd6
    } state_e;

endpackage

// File: rtl/axi_ram_slave.sv
// AXI4 slave front-end for a single-port synchronous RAM. Serves one
// single-beat transaction at a time; writes win over reads when both are
// offered in the same idle cycle. Bursts and out-of-range addresses are
// answered with an error response without touching the RAM.
module axi_ram_slave
    import axi_ram_slave_pkg::*;
#(
    parameter int RAM_AW = 14,
    parameter int ID_W   = 4
) (
    input  logic                  aclk,
    input  logic                  areset,
    // read address channel
    input  logic [ID_W-1:0]       arid,
    input  logic [AXI_ADDR_W-1:0] araddr,
    input  logic [AXI_LEN_W-1:0]  arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  arlock,
    input  logic [3:0]            arcache,
    input  logic [2:0]            arprot,
    input  logic                  arvalid,
    output logic                  arready,
    // read data channel
    output logic [ID_W-1:0]       rid,
    output logic [AXI_DATA_W-1:0] rdata,
    output logic [AXI_RESP_W-1:0] rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    // write address channel
    input  logic [ID_W-1:0]       awid,
    input  logic [AXI_ADDR_W-1:0] awaddr,
    input  logic [AXI_LEN_W-1:0]  awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic                  awlock,
    input  logic [3:0]            awcache,
    input  logic [2:0]            awprot,
    input  logic                  awvalid,
    output logic                  awready,
    // write data channel
    input  logic [AXI_DATA_W-1:0] wdata,
    input  logic [AXI_STRB_W-1:0] wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    // write response channel
    output logic [ID_W-1:0]       bid,
    output logic [AXI_RESP_W-1:0] bresp,
    output logic                  bvalid,
    input  logic                  bready,
    // RAM port
    output logic                  ram_en,
    output logic [AXI_STRB_W-1:0] ram_we,
    output logic [RAM_AW-1:0]     ram_addr,
    output logic [AXI_DATA_W-1:0] ram_wdata,
    input  logic [AXI_DATA_W-1:0] ram_rdata
);

    state_e                r_state;
    state_e                w_next;

    logic [ID_W-1:0]       r_arid;
    logic [RAM_AW-1:0]     r_raddr;
    resp_e                 r_rresp;
    logic [AXI_DATA_W-1:0] r_rdata;

    logic [ID_W-1:0]       r_awid;
    logic [RAM_AW-1:0]     r_waddr;
    resp_e                 r_bresp;
    logic                  r_aw_held;
    logic [AXI_DATA_W-1:0] r_wdata;
    logic [AXI_STRB_W-1:0] r_wstrb;
    logic                  r_w_held;

    logic                  w_ar_hs;
    logic                  w_aw_hs;
    logic                  w_w_hs;

    // Attributes and wlast carry no meaning for a single-beat slave; the
    // byte offset inside a word is likewise irrelevant.
    logic                  w_unused;
    assign w_unused = ^{arsize, arburst, arlock, arcache, arprot,
                        awsize, awburst, awlock, awcache, awprot,
                        wlast, araddr[1:0], awaddr[1:0]};

    // Response decided at request time: decode failure outranks a burst.
    function automatic resp_e f_check(input logic [AXI_ADDR_W-1:0] addr,
                                      input logic [AXI_LEN_W-1:0]  len);
        if (addr[AXI_ADDR_W-1:RAM_AW+2] != '0) begin
            return RESP_DECERR;
        end
        if (len != '0) begin
            return RESP_SLVERR;
        end
        return RESP_OKAY;
    endfunction

    assign rid       = r_arid;
    assign rdata     = r_rdata;
    assign rresp     = r_rresp;
    assign rlast     = rvalid;
    assign bid       = r_awid;
    assign bresp     = r_bresp;
    assign ram_wdata = r_wdata;

    // Controller state register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, handshake readies, response valids and RAM strobes.
    always_comb begin
        w_next   = r_state;
        w_ar_hs  = 1'b0;
        w_aw_hs  = 1'b0;
        w_w_hs   = 1'b0;
        arready  = 1'b0;
        awready  = 1'b0;
        wready   = 1'b0;
        rvalid   = 1'b0;
        bvalid   = 1'b0;
        ram_en   = 1'b0;
        ram_we   = '0;
        ram_addr = r_raddr;
        case (r_state)
            ST_IDLE: begin
                awready = 1'b1;
                wready  = 1'b1;
                arready = ~awvalid & ~wvalid;
                w_aw_hs = awvalid;
                w_w_hs  = wvalid;
                w_ar_hs = arvalid & ~awvalid & ~wvalid;
                if (awvalid && wvalid) begin
                    w_next = ST_WR_ISSUE;
                end else if (awvalid || wvalid) begin
                    w_next = ST_WR_COLLECT;
                end else if (arvalid) begin
                    w_next = ST_RD_ISSUE;
                end
            end
            ST_RD_ISSUE: begin
                ram_en = (r_rresp == RESP_OKAY);
                w_next = ST_RD_CAPT;
            end
            ST_RD_CAPT: begin
                w_next = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                rvalid = 1'b1;
                if (rready) begin
                    w_next = ST_IDLE;
                end
            end
            ST_WR_COLLECT: begin
                awready = ~r_aw_held;
                wready  = ~r_w_held;
                w_aw_hs = awvalid & ~r_aw_held;
                w_w_hs  = wvalid & ~r_w_held;
                if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) begin
                    w_next = ST_WR_ISSUE;
                end
            end
            ST_WR_ISSUE: begin
                ram_addr = r_waddr;
                if (r_bresp == RESP_OKAY) begin
                    ram_en = 1'b1;
                    ram_we = r_wstrb;
                end
                w_next = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Request latches and read-data capture; errored reads return zero data.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_arid    <= '0;
            r_raddr   <= '0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
            r_awid    <= '0;
            r_waddr   <= '0;
            r_bresp   <= RESP_OKAY;
            r_aw_held <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_w_held  <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                r_arid  <= arid;
                r_raddr <= araddr[RAM_AW+1:2];
                r_rresp <= f_check(araddr, arlen);
            end
            if (r_state == ST_RD_CAPT) begin
                r_rdata <= (r_rresp == RESP_OKAY) ? ram_rdata : '0;
            end
            if (w_aw_hs) begin
                r_awid    <= awid;
                r_waddr   <= awaddr[RAM_AW+1:2];
                r_bresp   <= f_check(awaddr, awlen);
                r_aw_held <= 1'b1;
            end
            if (w_w_hs) begin
                r_wdata  <= wdata;
                r_wstrb  <= wstrb;
                r_w_held <= 1'b1;
            end
            if (r_state == ST_WR_ISSUE) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Bench for axi_ram_slave: a behavioural RAM on the RAM port, a directed
// vector table, two hand-written corner sequences and a randomized phase
// checked against a transaction-level memory/response model.
module tb_axi_ram_slave;

    localparam int RAM_AW    = 14;
    localparam int ID_W      = 4;
    localparam int RAM_WORDS = 1 << RAM_AW;

    logic              aclk;
    logic              areset;
    logic [ID_W-1:0]   arid;
    logic [31:0]       araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;
    logic [ID_W-1:0]   awid;
    logic [31:0]       awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = '0;

    int n_run  = 0;
    int n_fail = 0;

    axi_ram_slave #(.RAM_AW(RAM_AW), .ID_W(ID_W)) dut (
        .aclk(aclk), .areset(areset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Behavioural single-port RAM with a preload side door.
    logic [31:0]       mem [0:RAM_WORDS-1];
    logic              pl_en   = 1'b0;
    logic [RAM_AW-1:0] pl_addr = '0;
    logic [31:0]       pl_data = '0;
    int                en_cnt  = 0;
    int                we_cnt  = 0;

    always @(posedge aclk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
            if (ram_we == 4'b0000) ram_rdata <= mem[ram_addr];
            en_cnt <= en_cnt + 1;
            if (ram_we != 4'b0000) we_cnt <= we_cnt + 1;
        end
    end

    // Reference model: words 0..15 of the address space.
    logic [31:0] exp_mem [0:15];

    function automatic logic [1:0] model_resp(input logic [31:0] addr, input logic [7:0] len);
        if (64'(addr) >= (64'd1 << (RAM_AW + 2))) return 2'b11;
        if (len != 8'd0) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [3:0]  w;
        logic [31:0] v;
        w = addr[5:2];
        v = exp_mem[w];
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) v[8*b +: 8] = data[8*b +: 8];
        end
        exp_mem[w] = v;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [RAM_AW-1:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge aclk); #1;
        pl_en = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input int hold, output logic [31:0] d, output logic [1:0] resp,
                           output logic [3:0] rid_o, output logic last_o, output int lat,
                           output logic stable, output int en_d, output logic tmo);
        int   t;
        int   e0;
        logic fire;
        e0 = en_cnt; tmo = 1'b0; stable = 1'b1; fire = 1'b0; t = 0; en_d = 0;
        d = '0; resp = '0; rid_o = '0; last_o = 1'b0; lat = 0;
        arid = id; araddr = addr; arlen = len; arvalid = 1'b1; rready = (hold == 0);
        while (!fire && t < 20) begin
            @(negedge aclk); fire = arready;
            @(posedge aclk); #1; t++;
        end
        arvalid = 1'b0;
        if (!fire) begin tmo = 1'b1; rready = 1'b0; return; end
        // cycle 1 is the one right after the handshake cycle
        lat = 1;
        while (!rvalid && lat < 20) begin @(posedge aclk); #1; lat++; end
        if (!rvalid) begin tmo = 1'b1; rready = 1'b0; return; end
        d = rdata; resp = rresp; rid_o = rid; last_o = rlast;
        for (int i = 0; i < hold; i++) begin
            @(posedge aclk); #1;
            if (rvalid !== 1'b1 || rdata !== d || rid !== rid_o || rresp !== resp || rlast !== last_o)
                stable = 1'b0;
        end
        rready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0;
        en_d = en_cnt - e0;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [31:0] data, input logic [3:0] strb, input int aw_d, input int w_d,
                            output logic [3:0] bid_o, output logic [1:0] bresp_o,
                            output int en_d, output int we_d, output logic tmo);
        int   t;
        int   e0;
        int   w0;
        logic aw_done, w_done, aw_fire, w_fire;
        e0 = en_cnt; w0 = we_cnt; t = 0; tmo = 1'b0; en_d = 0; we_d = 0;
        aw_done = 1'b0; w_done = 1'b0; bid_o = '0; bresp_o = '0;
        awid = id; awaddr = addr; awlen = len; wdata = data; wstrb = strb;
        while (!(aw_done && w_done) && t < 30) begin
            awvalid = !aw_done && (t >= aw_d);
            wvalid  = !w_done && (t >= w_d);
            @(negedge aclk);
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(posedge aclk); #1;
            if (aw_fire) aw_done = 1'b1;
            if (w_fire)  w_done  = 1'b1;
            t++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (!(aw_done && w_done)) begin tmo = 1'b1; return; end
        bready = 1'b1;
        t = 0;
        while (!bvalid && t < 20) begin @(posedge aclk); #1; t++; end
        if (!bvalid) begin tmo = 1'b1; bready = 1'b0; return; end
        bid_o = bid; bresp_o = bresp;
        @(posedge aclk); #1;
        bready = 1'b0;
        en_d = en_cnt - e0;
        we_d = we_cnt - w0;
    endtask

    typedef struct {
        logic        is_wr;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_d;
        int          w_d;
        int          hold;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int          exp_en;
        int          exp_we;
    } vec_t;

    vec_t vecs [13];

    task automatic run_table();
        logic [31:0] d;
        logic [1:0]  resp;
        logic [3:0]  idr;
        logic        last, stable, tmo;
        int          lat, en_d, we_d;
        vecs[0]  = '{1'b0, 4'd3,  32'h0000_0100, 8'd0, 32'h0,          4'h0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF, 1, 0};
        vecs[1]  = '{1'b0, 4'd1,  32'h0000_0004, 8'd0, 32'h0,          4'h0, 0, 0, 5, 2'b00, 32'hC0DE_0001, 1, 0};
        vecs[2]  = '{1'b0, 4'd2,  32'h0000_0004, 8'd1, 32'h0,          4'h0, 0, 0, 0, 2'b10, 32'h0,         0, 0};
        vecs[3]  = '{1'b0, 4'd7,  32'h0001_0000, 8'd0, 32'h0,          4'h0, 0, 0, 0, 2'b11, 32'h0,         0, 0};
        vecs[4]  = '{1'b1, 4'd5,  32'h0000_0008, 8'd0, 32'h1234_5678,  4'h3, 2, 0, 0, 2'b00, 32'h0,         1, 1};
        vecs[5]  = '{1'b0, 4'd5,  32'h0000_0008, 8'd0, 32'h0,          4'h0, 0, 0, 0, 2'b00, 32'hFFFF_5678, 1, 0};
        vecs[6]  = '{1'b1, 4'd9,  32'h0000_000C, 8'd0, 32'h0,          4'h0, 0, 0, 0, 2'b00, 32'h0,         1, 0};
        vecs[7]  = '{1'b0, 4'd0,  32'h0000_000C, 8'd0, 32'h0,          4'h0, 0, 0, 1, 2'b00, 32'hC0DE_0003, 1, 0};
        vecs[8]  = '{1'b1, 4'd4,  32'h0000_0010, 8'd2, 32'h0000_0001,  4'hF, 0, 0, 0, 2'b10, 32'h0,         0, 0};
        vecs[9]  = '{1'b1, 4'd6,  32'h0002_0000, 8'd0, 32'h0000_0001,  4'hF, 1, 0, 0, 2'b11, 32'h0,         0, 0};
        vecs[10] = '{1'b1, 4'd10, 32'h0000_0014, 8'd0, 32'hAABB_CCDD,  4'hC, 0, 3, 0, 2'b00, 32'h0,         1, 1};
        vecs[11] = '{1'b0, 4'd10, 32'h0000_0014, 8'd0, 32'h0,          4'h0, 0, 0, 0, 2'b00, 32'hAABB_0005, 1, 0};
        vecs[12] = '{1'b0, 4'd15, 32'h0000_0010, 8'd0, 32'h0,          4'h0, 0, 0, 2, 2'b00, 32'hC0DE_0004, 1, 0};
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].data, vecs[i].strb,
                         vecs[i].aw_d, vecs[i].w_d, idr, resp, en_d, we_d, tmo);
                chk($sformatf("v%0d_wr_timeout", i), tmo, 0);
                chk($sformatf("v%0d_bresp", i), resp, vecs[i].exp_resp);
                chk($sformatf("v%0d_bid", i), idr, vecs[i].id);
                chk($sformatf("v%0d_ram_en", i), en_d, vecs[i].exp_en);
                chk($sformatf("v%0d_ram_we", i), we_d, vecs[i].exp_we);
                if (vecs[i].exp_resp == 2'b00 && vecs[i].addr < 32'h40)
                    model_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            end else begin
                do_read(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].hold,
                        d, resp, idr, last, lat, stable, en_d, tmo);
                chk($sformatf("v%0d_rd_timeout", i), tmo, 0);
                chk($sformatf("v%0d_rresp", i), resp, vecs[i].exp_resp);
                chk($sformatf("v%0d_rdata", i), d, vecs[i].exp_rdata);
                chk($sformatf("v%0d_rid", i), idr, vecs[i].id);
                chk($sformatf("v%0d_rlast", i), last, 1);
                chk($sformatf("v%0d_rd_latency", i), lat, 3);
                chk($sformatf("v%0d_ram_en", i), en_d, vecs[i].exp_en);
                chk($sformatf("v%0d_rvalid_drop", i), rvalid, 0);
                if (vecs[i].hold > 0) chk($sformatf("v%0d_r_stable", i), stable, 1);
            end
        end
    endtask

    // AW, W and AR offered together: write first, read right after B.
    task automatic seq_priority();
        int          cyc, b_cyc, ar_cyc, t;
        logic [3:0]  b_id;
        logic [31:0] d;
        awid = 4'd2; awaddr = 32'h18; awlen = 8'd0; wdata = 32'h5A5A_5A5A; wstrb = 4'hF;
        arid = 4'd3; araddr = 32'h18; arlen = 8'd0;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        @(negedge aclk);
        chk("prio_arready", arready, 0);
        chk("prio_awready", awready, 1);
        chk("prio_wready", wready, 1);
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        cyc = 0; b_cyc = -1; ar_cyc = -1; b_id = '0;
        while ((b_cyc < 0 || ar_cyc < 0) && cyc < 30) begin
            @(negedge aclk);
            if (bvalid && b_cyc < 0) begin b_cyc = cyc; b_id = bid; end
            if (arvalid && arready && ar_cyc < 0) ar_cyc = cyc;
            @(posedge aclk); #1;
            if (ar_cyc >= 0) arvalid = 1'b0;
            cyc++;
        end
        arvalid = 1'b0; bready = 1'b0;
        chk("prio_timeout", (b_cyc >= 0 && ar_cyc >= 0), 1);
        chk("prio_bid", b_id, 4'd2);
        chk("prio_ar_after_b", ar_cyc, b_cyc + 1);
        model_write(32'h18, 32'h5A5A_5A5A, 4'hF);
        t = 0;
        while (!rvalid && t < 10) begin @(posedge aclk); #1; t++; end
        d = rdata;
        chk("prio_rvalid", rvalid, 1);
        chk("prio_rdata", d, exp_mem[6]);
        chk("prio_rid", rid, 4'd3);
        @(posedge aclk); #1;
        rready = 1'b0;
    endtask

    // Reset while waiting for the W half of a write.
    task automatic seq_reset_collect();
        int   e0;
        logic saw_en, saw_b;
        e0 = en_cnt;
        awid = 4'd1; awaddr = 32'h1C; awlen = 8'd0; wdata = 32'h0BAD_0BAD; wstrb = 4'hF;
        awvalid = 1'b1;
        @(posedge aclk); #1;
        awvalid = 1'b0;
        chk("collect_awready", awready, 0);
        chk("collect_wready", wready, 1);
        #2 areset = 1'b1;
        #1;
        chk("rstmid_bvalid", bvalid, 0);
        chk("rstmid_ram_en", ram_en, 0);
        @(posedge aclk); @(posedge aclk); #1;
        areset = 1'b0;
        saw_en = 1'b0; saw_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge aclk); #1;
            if (ram_en) saw_en = 1'b1;
            if (bvalid) saw_b = 1'b1;
        end
        chk("rstmid_no_ram_en", saw_en, 0);
        chk("rstmid_no_bvalid", saw_b, 0);
        chk("rstmid_en_count", en_cnt - e0, 0);
        chk("rstmid_idle_awready", awready, 1);
        chk("rstmid_idle_arready", arready, 1);
    endtask

    task automatic run_random(input int n);
        logic [31:0] addr, data, d;
        logic [7:0]  len;
        logic [3:0]  id, strb, idr;
        logic [1:0]  exp, resp;
        logic        last, stable, tmo;
        int          w, kind, lat, en_d, we_d, hold;
        for (int i = 0; i < n; i++) begin
            w = $urandom_range(0, 15);
            kind = $urandom_range(0, 7);
            addr = 32'(w * 4);
            len = 8'd0;
            if (kind == 0) len = 8'($urandom_range(1, 255));
            else if (kind == 1) addr = {16'($urandom_range(1, 65535)), 16'(w * 4)};
            id = 4'($urandom);
            exp = model_resp(addr, len);
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom;
                strb = 4'($urandom);
                do_write(id, addr, len, data, strb, $urandom_range(0, 3), $urandom_range(0, 3),
                         idr, resp, en_d, we_d, tmo);
                chk($sformatf("rnd%0d_wr_timeout", i), tmo, 0);
                chk($sformatf("rnd%0d_bresp", i), resp, exp);
                chk($sformatf("rnd%0d_bid", i), idr, id);
                chk($sformatf("rnd%0d_wr_ram_en", i), en_d, (exp == 2'b00) ? 1 : 0);
                chk($sformatf("rnd%0d_wr_ram_we", i), we_d, (exp == 2'b00 && strb != 4'h0) ? 1 : 0);
                if (exp == 2'b00) model_write(addr, data, strb);
            end else begin
                hold = $urandom_range(0, 2);
                do_read(id, addr, len, hold, d, resp, idr, last, lat, stable, en_d, tmo);
                chk($sformatf("rnd%0d_rd_timeout", i), tmo, 0);
                chk($sformatf("rnd%0d_rresp", i), resp, exp);
                chk($sformatf("rnd%0d_rdata", i), d, (exp == 2'b00) ? exp_mem[w] : 32'h0);
                chk($sformatf("rnd%0d_rid", i), idr, id);
                chk($sformatf("rnd%0d_rlast", i), last, 1);
                chk($sformatf("rnd%0d_rd_latency", i), lat, 3);
                chk($sformatf("rnd%0d_rd_ram_en", i), en_d, (exp == 2'b00) ? 1 : 0);
                if (hold > 0) chk($sformatf("rnd%0d_r_stable", i), stable, 1);
            end
        end
    endtask

    initial begin
        areset = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        arsize = 3'd2; arburst = 2'b01; arlock = 1'b0; arcache = 4'h0; arprot = 3'd0;
        awsize = 3'd2; awburst = 2'b01; awlock = 1'b0; awcache = 4'h0; awprot = 3'd0;
        wlast = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rid", rid, 0);
        chk("rst_bid", bid, 0);
        @(posedge aclk); #1;
        areset = 1'b0;
        #1;
        chk("rst_arready", arready, 1);
        chk("rst_awready", awready, 1);
        chk("rst_wready", wready, 1);
        for (int i = 0; i < 16; i++) begin
            exp_mem[i] = (i == 2) ? 32'hFFFF_FFFF : 32'hC0DE_0000 + 32'(i);
            preload(RAM_AW'(i), exp_mem[i]);
        end
        preload(RAM_AW'(32'h40), 32'hDEAD_BEEF);
        run_table();
        seq_priority();
        seq_reset_collect();
        run_random(80);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_run, n_fail);
        $fatal(1);
    end

endmodule
